// File: rtl/wb_pkg.sv
// ============================================================================
// wb_pkg -- shared types and constants for the writeback stage
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_CSR  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] c_LD_LB  = 3'b000;
  localparam logic [2:0] c_LD_LH  = 3'b001;
  localparam logic [2:0] c_LD_LW  = 3'b010;
  localparam logic [2:0] c_LD_LBU = 3'b100;
  localparam logic [2:0] c_LD_LHU = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_LD_WAIT = 1'b1
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_unit_ld_align.sv
// ============================================================================
// ld_align -- byte/halfword selection and sign/zero extension of load data
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module ld_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  // Reserved funct3 encodings fall through to the full-word path.
  always_comb begin
    o_data = i_word;
    case (i_funct3)
      c_LD_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_LD_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
      c_LD_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
      c_LD_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
      default:  o_data = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_unit.sv
// ============================================================================
// wb_unit -- writeback stage: source select, load extension, late-load wait
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module wb_unit
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_wb_sel,
  input  logic              i_rd_wren,
  input  logic [REG_AW-1:0] i_rd_addr,
  input  logic [XLEN-1:0]   i_alu_data,
  input  logic [XLEN-1:0]   i_pc_four,
  input  logic [XLEN-1:0]   i_csr_data,
  input  logic [2:0]        i_ld_funct3,
  input  logic [XLEN-1:0]   i_ld_data,
  input  logic              i_ld_valid,
  input  logic              i_flush,
  output logic              o_rf_wren,
  output logic [REG_AW-1:0] o_rf_addr,
  output logic [XLEN-1:0]   o_rf_data,
  output logic              o_busy
);

  wb_state_e         r_state;
  logic              r_rf_wren;
  logic [REG_AW-1:0] r_rf_addr;
  logic [XLEN-1:0]   r_rf_data;
  logic              r_ld_wren;
  logic [REG_AW-1:0] r_ld_addr;
  logic [2:0]        r_ld_funct3;
  logic [1:0]        r_ld_off;

  logic              w_in_wait;
  logic [2:0]        w_al_funct3;
  logic [1:0]        w_al_off;
  logic [XLEN-1:0]   w_ld_ext;
  logic [XLEN-1:0]   w_src;
  logic              w_req_we;
  logic              w_wait_we;

  // While waiting, the aligner must see the captured context, not live inputs.
  assign w_in_wait   = (r_state == S_LD_WAIT);
  assign w_al_funct3 = w_in_wait ? r_ld_funct3 : i_ld_funct3;
  assign w_al_off    = w_in_wait ? r_ld_off : i_alu_data[1:0];

  ld_align #(
    .XLEN(XLEN)
  ) u_ld_align (
    .i_word   (i_ld_data),
    .i_offset (w_al_off),
    .i_funct3 (w_al_funct3),
    .o_data   (w_ld_ext)
  );

  always_comb begin
    w_src = i_alu_data;
    case (i_wb_sel)
      WB_LOAD: w_src = w_ld_ext;
      WB_PC4:  w_src = i_pc_four;
      WB_CSR:  w_src = i_csr_data;
      default: w_src = i_alu_data;
    endcase
  end

  assign w_req_we  = i_rd_wren && (i_rd_addr != '0);
  assign w_wait_we = r_ld_wren && (r_ld_addr != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_rf_wren   <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_data   <= '0;
      r_ld_wren   <= 1'b0;
      r_ld_addr   <= '0;
      r_ld_funct3 <= '0;
      r_ld_off    <= '0;
    end else begin
      r_rf_wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            if ((i_wb_sel == WB_LOAD) && !i_ld_valid) begin
              r_ld_wren   <= i_rd_wren;
              r_ld_addr   <= i_rd_addr;
              r_ld_funct3 <= i_ld_funct3;
              r_ld_off    <= i_alu_data[1:0];
              r_state     <= S_LD_WAIT;
            end else if (w_req_we) begin
              // Address/data only move on a real write so they hold otherwise.
              r_rf_wren <= 1'b1;
              r_rf_addr <= i_rd_addr;
              r_rf_data <= w_src;
            end
          end
        end
        S_LD_WAIT: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else if (i_ld_valid) begin
            r_state <= S_IDLE;
            if (w_wait_we) begin
              r_rf_wren <= 1'b1;
              r_rf_addr <= r_ld_addr;
              r_rf_data <= w_ld_ext;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready   = !w_in_wait;
  assign o_busy    = w_in_wait;
  assign o_rf_wren = r_rf_wren;
  assign o_rf_addr = r_rf_addr;
  assign o_rf_data = r_rf_data;

endmodule

`default_nettype wire

// File: tb/tb_wb_unit.sv
// ============================================================================
// tb_wb_unit -- self-checking bench for wb_unit
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_wb_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid, i_rd_wren, i_ld_valid, i_flush;
  logic [1:0]  i_wb_sel;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_alu_data, i_pc_four, i_csr_data, i_ld_data;
  logic [2:0]  i_ld_funct3;
  logic        o_ready, o_rf_wren, o_busy;
  logic [4:0]  o_rf_addr;
  logic [31:0] o_rf_data;

  int total = 0;
  int bad = 0;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  wb_unit #(.XLEN(32), .REG_AW(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_wb_sel(i_wb_sel), .i_rd_wren(i_rd_wren), .i_rd_addr(i_rd_addr),
    .i_alu_data(i_alu_data), .i_pc_four(i_pc_four), .i_csr_data(i_csr_data),
    .i_ld_funct3(i_ld_funct3), .i_ld_data(i_ld_data), .i_ld_valid(i_ld_valid),
    .i_flush(i_flush), .o_rf_wren(o_rf_wren), .o_rf_addr(o_rf_addr),
    .o_rf_data(o_rf_data), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_wb_sel = 0; i_rd_wren = 0; i_rd_addr = 0;
    i_alu_data = 0; i_pc_four = 0; i_csr_data = 0; i_ld_funct3 = 0;
    i_ld_data = 0; i_ld_valid = 0; i_flush = 0;
  endtask

  // Reference load extension by plain shifting and modular arithmetic.
  function automatic logic [31:0] ref_ext(logic [31:0] word, int off, int f3);
    int unsigned v;
    case (f3)
      0: begin v = (word >> (8 * off)) % 256;          if (v >= 128)   v = v + 32'hFFFF_FF00; end
      4: v = (word >> (8 * off)) % 256;
      1: begin v = (word >> (16 * (off / 2))) % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      5: v = (word >> (16 * (off / 2))) % 65536;
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic test_reset();
    idle_inputs();
    #3;
    total++;
    if ({o_rf_wren, o_rf_addr, o_rf_data, o_ready, o_busy} !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got wren=%0b addr=%0d data=%h ready=%0b busy=%0b, want 0 0 0 1 0",
               o_rf_wren, o_rf_addr, o_rf_data, o_ready, o_busy);
    end
    tick(); tick();
    i_rst_n = 1'b1;
    m_addr = 0; m_data = 0;
  endtask

  // Issued in the same cycle reset is released: accepted at the first edge.
  task automatic test_alu();
    i_valid = 1; i_wb_sel = 2'b00; i_rd_wren = 1; i_rd_addr = 5; i_alu_data = 32'h1234_5678;
    tick(); idle_inputs();
    total++;
    if ({o_rf_wren, o_rf_addr, o_rf_data} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      bad++;
      $display("FAIL alu_write: got wren=%0b addr=%0d data=%h, want 1 5 12345678", o_rf_wren, o_rf_addr, o_rf_data);
    end
    tick();
    total++;
    if ({o_rf_wren, o_rf_addr, o_rf_data} !== {1'b0, 5'd5, 32'h1234_5678}) begin
      bad++;
      $display("FAIL alu_pulse_hold: got wren=%0b addr=%0d data=%h, want 0 5 12345678", o_rf_wren, o_rf_addr, o_rf_data);
    end
  endtask

  task automatic test_late_load();
    i_valid = 1; i_wb_sel = 2'b01; i_rd_wren = 1; i_rd_addr = 7;
    i_alu_data = 32'h0000_0003; i_ld_funct3 = 3'b000; i_ld_valid = 0;
    tick(); idle_inputs();
    i_ld_funct3 = 3'b010;
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({o_ready, o_busy, o_rf_wren} !== 3'b010) begin
        bad++;
        $display("FAIL late_wait%0d: got ready=%0b busy=%0b wren=%0b, want 0 1 0", c, o_ready, o_busy, o_rf_wren);
      end
      if (c < 2) tick();
    end
    i_ld_valid = 1; i_ld_data = 32'h80FF_0000;
    tick(); idle_inputs();
    total++;
    if ({o_rf_wren, o_rf_addr, o_rf_data, o_ready, o_busy} !== {1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL late_write: got wren=%0b addr=%0d data=%h ready=%0b, want 1 7 ffffff80 1",
               o_rf_wren, o_rf_addr, o_rf_data, o_ready);
    end
  endtask

  task automatic test_extension();
    logic [2:0]  f3s [3] = '{3'b001, 3'b101, 3'b100};
    logic [1:0]  offs[3] = '{2'd0, 2'd0, 2'd1};
    logic [31:0] exps[3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_0080};
    for (int k = 0; k < 3; k++) begin
      i_valid = 1; i_wb_sel = 2'b01; i_rd_wren = 1; i_rd_addr = 5'(10 + k);
      i_alu_data = {30'd0, offs[k]}; i_ld_funct3 = f3s[k];
      i_ld_valid = 1; i_ld_data = 32'h0000_8001;
      tick(); idle_inputs();
      total++;
      if ({o_rf_wren, o_rf_addr, o_rf_data, o_ready} !== {1'b1, 5'(10 + k), exps[k], 1'b1}) begin
        bad++;
        $display("FAIL ext_case%0d: got wren=%0b addr=%0d data=%h, want 1 %0d %h",
                 k, o_rf_wren, o_rf_addr, o_rf_data, 10 + k, exps[k]);
      end
    end
    m_addr = 12; m_data = 32'h0000_0080;
  endtask

  task automatic test_flush();
    i_valid = 1; i_wb_sel = 2'b01; i_rd_wren = 1; i_rd_addr = 9; i_ld_funct3 = 3'b010; i_ld_valid = 0;
    tick(); idle_inputs();
    i_flush = 1; i_ld_valid = 1; i_ld_data = 32'hCAFE_F00D;
    tick(); idle_inputs();
    total++;
    if ({o_rf_wren, o_rf_addr, o_rf_data, o_ready, o_busy} !== {1'b0, m_addr, m_data, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL flush_wait: got wren=%0b addr=%0d data=%h ready=%0b busy=%0b, want 0 %0d %h 1 0",
               o_rf_wren, o_rf_addr, o_rf_data, o_ready, o_busy, m_addr, m_data);
    end
    i_valid = 1; i_wb_sel = 2'b10; i_rd_wren = 1; i_rd_addr = 4; i_pc_four = 32'h0000_1004; i_flush = 1;
    tick(); idle_inputs();
    total++;
    if ({o_rf_wren, o_rf_addr, o_rf_data} !== {1'b1, 5'd4, 32'h0000_1004}) begin
      bad++;
      $display("FAIL flush_idle: got wren=%0b addr=%0d data=%h, want 1 4 00001004", o_rf_wren, o_rf_addr, o_rf_data);
    end
    m_addr = 4; m_data = 32'h0000_1004;
  endtask

  task automatic test_x0_csr();
    i_valid = 1; i_wb_sel = 2'b11; i_rd_wren = 1; i_rd_addr = 0; i_csr_data = 32'hDEAD_BEEF;
    tick();
    total++;
    if ({o_rf_wren, o_rf_addr, o_rf_data} !== {1'b0, m_addr, m_data}) begin
      bad++;
      $display("FAIL x0_suppress: got wren=%0b addr=%0d data=%h, want 0 %0d %h", o_rf_wren, o_rf_addr, o_rf_data, m_addr, m_data);
    end
    i_rd_addr = 3;
    tick(); idle_inputs();
    total++;
    if ({o_rf_wren, o_rf_addr, o_rf_data} !== {1'b1, 5'd3, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL csr_write: got wren=%0b addr=%0d data=%h, want 1 3 deadbeef", o_rf_wren, o_rf_addr, o_rf_data);
    end
  endtask

  task automatic test_reset_in_wait();
    i_valid = 1; i_wb_sel = 2'b01; i_rd_wren = 1; i_rd_addr = 8; i_ld_funct3 = 3'b010; i_ld_valid = 0;
    tick(); idle_inputs();
    i_rst_n = 0;
    #1;
    total++;
    if ({o_rf_wren, o_rf_addr, o_rf_data, o_ready, o_busy} !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_async: got wren=%0b addr=%0d data=%h ready=%0b busy=%0b, want 0 0 0 1 0",
               o_rf_wren, o_rf_addr, o_rf_data, o_ready, o_busy);
    end
    tick(); tick();
    i_rst_n = 1; i_ld_valid = 1; i_ld_data = 32'hFFFF_FFFF;
    tick(); idle_inputs();
    total++;
    if ({o_rf_wren, o_rf_addr, o_rf_data, o_ready} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_discard: got wren=%0b addr=%0d data=%h ready=%0b, want 0 0 0 1",
               o_rf_wren, o_rf_addr, o_rf_data, o_ready);
    end
    m_addr = 0; m_data = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int          sel, rd, f3, nwait;
      bit          we, late, fl;
      logic [31:0] alu, pc, csr, word, val;
      sel = $urandom_range(0, 3); rd = $urandom_range(0, 31); f3 = $urandom_range(0, 7);
      we = ($urandom_range(0, 3) != 0);
      alu = $urandom; pc = $urandom; csr = $urandom; word = $urandom;
      late = (sel == 1) && ($urandom_range(0, 1) == 1);
      i_valid = 1; i_wb_sel = 2'(sel); i_rd_wren = we; i_rd_addr = 5'(rd);
      i_alu_data = alu; i_pc_four = pc; i_csr_data = csr; i_ld_funct3 = 3'(f3);
      i_ld_valid = !late; i_ld_data = late ? $urandom : word; i_flush = 1'($urandom_range(0, 1));
      case (sel)
        1: val = ref_ext(word, alu % 4, f3);
        2: val = pc;
        3: val = csr;
        default: val = alu;
      endcase
      if (!late && we && rd != 0) begin m_addr = 5'(rd); m_data = val; end
      tick();
      total++;
      if ({o_rf_wren, o_rf_addr, o_rf_data, o_ready, o_busy} !==
          {!late && we && rd != 0, m_addr, m_data, !late, late}) begin
        bad++;
        $display("FAIL rnd_accept n=%0d: got wren=%0b addr=%0d data=%h ready=%0b busy=%0b, want wren=%0b addr=%0d data=%h late=%0b",
                 n, o_rf_wren, o_rf_addr, o_rf_data, o_ready, o_busy, !late && we && rd != 0, m_addr, m_data, late);
      end
      if (late) begin
        nwait = $urandom_range(0, 3);
        for (int w = 0; w < nwait; w++) begin
          i_valid = 1'($urandom_range(0, 1)); i_alu_data = $urandom; i_ld_funct3 = 3'($urandom_range(0, 7));
          i_rd_addr = 5'($urandom_range(0, 31)); i_ld_valid = 0; i_flush = 0; i_ld_data = $urandom;
          tick();
          total++;
          if ({o_rf_wren, o_rf_addr, o_rf_data, o_ready, o_busy} !== {1'b0, m_addr, m_data, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL rnd_wait n=%0d: got wren=%0b addr=%0d data=%h ready=%0b busy=%0b, want 0 %0d %h 0 1",
                     n, o_rf_wren, o_rf_addr, o_rf_data, o_ready, o_busy, m_addr, m_data);
          end
        end
        fl = ($urandom_range(0, 3) == 0);
        i_valid = 1'($urandom_range(0, 1)); i_alu_data = $urandom; i_ld_funct3 = 3'($urandom_range(0, 7));
        i_ld_valid = 1; i_ld_data = word; i_flush = fl;
        if (!fl && we && rd != 0) begin m_addr = 5'(rd); m_data = val; end
        tick();
        total++;
        if ({o_rf_wren, o_rf_addr, o_rf_data, o_ready, o_busy} !== {!fl && we && rd != 0, m_addr, m_data, 1'b1, 1'b0}) begin
          bad++;
          $display("FAIL rnd_complete n=%0d: got wren=%0b addr=%0d data=%h ready=%0b, want wren=%0b addr=%0d data=%h flush=%0b",
                   n, o_rf_wren, o_rf_addr, o_rf_data, o_ready, !fl && we && rd != 0, m_addr, m_data, fl);
        end
      end
      if ($urandom_range(0, 4) == 0) begin
        idle_inputs();
        tick();
        total++;
        if ({o_rf_wren, o_rf_addr, o_rf_data, o_ready} !== {1'b0, m_addr, m_data, 1'b1}) begin
          bad++;
          $display("FAIL rnd_idle n=%0d: got wren=%0b addr=%0d data=%h ready=%0b, want 0 %0d %h 1",
                   n, o_rf_wren, o_rf_addr, o_rf_data, o_ready, m_addr, m_data);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_late_load();
    test_extension();
    test_flush();
    test_x0_csr();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: XLEN, default 32, datapath width in bits.
REQ-003 Parameter: REG_AW, default 5, register-file address width.
REQ-004 i_clk  input  1  clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_valid  input  1  upstream MEM stage presents a writeback request.
REQ-007 o_ready  output  1  unit can accept a request this cycle.
REQ-008 i_wb_sel  input  2  source: 00 ALU, 01 LOAD, 10 PC+4, 11 CSR.
REQ-009 i_rd_wren  input  1  request writes the register file.
REQ-010 i_rd_addr  input  REG_AW  destination register.
REQ-011 i_alu_data, i_pc_four, i_csr_data  input  XLEN  candidate sources; i_alu_data[1:0] is also the load byte offset.
REQ-012 i_ld_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-013 i_ld_data  input  XLEN  raw aligned word from data memory.
REQ-014 i_ld_valid  input  1  i_ld_data is valid this cycle.
REQ-015 i_flush  input  1  cancel any pending load writeback.
REQ-016 o_rf_wren  output  1  register-file write strobe, one-cycle pulse.
REQ-017 o_rf_addr  output  REG_AW; o_rf_data  output  XLEN  registered write port.
REQ-018 o_busy  output  1  high while a load is pending.

Function
REQ-019 FSM states SHALL be IDLE and LD_WAIT; o_ready=1 only in IDLE; o_busy=1 only in LD_WAIT.
REQ-020 In IDLE, request accepted when i_valid=1; the flopped write port updates at the next edge (latency 1).
REQ-021 Non-load source (00, 10, 11): o_rf_data = selected source, o_rf_wren = i_rd_wren.
REQ-022 LOAD with i_ld_valid=1 in the accept cycle: write the extended load data next edge; stay IDLE.
REQ-023 LOAD with i_ld_valid=0: capture rd_addr, rd_wren, funct3, offset; go LD_WAIT; o_rf_wren=0.
REQ-024 LD_WAIT: on i_ld_valid=1, write extended data next edge and return IDLE; else hold.
REQ-025 i_flush=1 in LD_WAIT SHALL return to IDLE with no write, even if i_ld_valid=1 that cycle (flush wins).
REQ-026 i_flush in IDLE SHALL have no effect; accepted requests still complete.
REQ-027 Load extension: LB/LBU select byte offset[1:0], LH/LHU select halfword offset[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes through the word.
REQ-028 Unlisted funct3 values SHALL behave as LW.
REQ-029 Writes to address 0 SHALL be suppressed: o_rf_wren=0 whenever destination is 0.
REQ-030 o_rf_wren SHALL be 0 in any cycle not following a completing write.
REQ-031 o_rf_addr/o_rf_data SHALL hold last values when o_rf_wren=0.

Reset
REQ-032 Reset asserted SHALL immediately force state IDLE, o_rf_wren=0, o_rf_addr=0, o_rf_data=0, o_busy=0; captured load context cleared.
REQ-033 Reset mid-LD_WAIT SHALL discard the pending load; no write after release.
REQ-034 First request is accepted on the first rising edge after i_rst_n deasserts.

Structure
REQ-035 Package wb_pkg SHALL hold the wb_sel enum (WB_ALU, WB_LOAD, WB_PC4, WB_CSR), funct3 load constants and the FSM state enum.
REQ-036 Combinational sub-module ld_align SHALL implement REQ-027/028 (inputs word, offset, funct3; output XLEN).

Verification
REQ-037 ALU: wb_sel=00, rd=5, alu=0x1234_5678 -> next cycle o_rf_wren=1, addr=5, data=0x1234_5678.
REQ-038 Late load: LB, offset=3, rd=7, ld_valid low 3 cycles then word 0x80FF_0000 -> o_ready=0 for 3 cycles, then write 0xFFFF_FF80 to x7.
REQ-039 Extension: word 0x0000_8001 with LH off0 -> 0xFFFF_8001; LHU off0 -> 0x0000_8001; LBU off1 -> 0x0000_0080.
REQ-040 Flush: LW pending, i_flush and i_ld_valid together -> no write, IDLE next cycle, o_ready=1.
REQ-041 x0 / CSR: wb_sel=11, rd=0, csr=0xDEAD_BEEF -> o_rf_wren=0; same with rd=3 -> write 0xDEAD_BEEF.
REQ-042 Reset in LD_WAIT: all outputs 0 asynchronously; later i_ld_valid causes no write.
